// File: rtl/clock_ui_controller.sv
// User-interface front end for ps1_clock: button conditioning, mode/field
// sequencing, auto-repeating inc/dec strobes and buzzer arbitration.
module clock_ui_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned HOLD_CYCLES     = 50000000,
  parameter int unsigned REPEAT_CYCLES   = 10000000,
  parameter int unsigned BUZZ_TIMEOUT_S  = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_select,
  input  logic       btn_start,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic       alarm_req,
  input  logic       timer_req,
  output logic [1:0] mode,
  output logic [1:0] selected,
  output logic       startstop,
  output logic       increment,
  output logic       decrement,
  output logic       buzzer,
  output logic [1:0] ring_src,
  output logic       silence_ack
);

  localparam int unsigned DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned CMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int unsigned TW   = (BUZZ_TIMEOUT_S > 1) ? $clog2(BUZZ_TIMEOUT_S) : 1;

  localparam int unsigned B_MODE = 0;
  localparam int unsigned B_SEL  = 1;
  localparam int unsigned B_STRT = 2;
  localparam int unsigned B_INC  = 3;
  localparam int unsigned B_DEC  = 4;

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} rp_state_t;
  typedef enum logic [1:0] {BZ_IDLE, BZ_RING, BZ_MUTED} bz_state_t;

  logic [4:0]    raw;
  logic [4:0]    sync1_q, sync1_d, sync2_q, sync2_d;
  logic [4:0]    stable_q, stable_d, stable_dly_q, stable_dly_d;
  logic [DW-1:0] db_cnt_q [5];
  logic [DW-1:0] db_cnt_d [5];
  logic [4:0]    press;

  logic [1:0]    mode_q, mode_d, selected_q, selected_d;
  logic          startstop_q, startstop_d;
  logic          increment_q, increment_d, decrement_q, decrement_d;

  rp_state_t     rp_q, rp_d;
  logic [CW-1:0] rp_cnt_q, rp_cnt_d;
  logic          rp_inc_q, rp_inc_d;
  logic          lock_q, lock_d;
  logic          both_held, active_held;

  bz_state_t     bz_q, bz_d;
  logic [TW-1:0] sec_cnt_q, sec_cnt_d;
  logic          beep_phase_q, beep_phase_d;
  logic          alarm_prev_q, alarm_prev_d, timer_prev_q, timer_prev_d;
  logic          buzzer_q, buzzer_d;
  logic [1:0]    ring_src_q, ring_src_d;
  logic          silence_ack_q, silence_ack_d;
  logic          rise_a, rise_t, src_req;

  assign raw         = {btn_dec, btn_inc, btn_start, btn_select, btn_mode};
  assign press       = stable_q & ~stable_dly_q;
  assign both_held   = stable_q[B_INC] & stable_q[B_DEC];
  assign active_held = rp_inc_q ? stable_q[B_INC] : stable_q[B_DEC];
  assign rise_a      = alarm_req & ~alarm_prev_q;
  assign rise_t      = timer_req & ~timer_prev_q;
  assign src_req     = (ring_src_q == 2'd1) ? alarm_req : timer_req;

  always_comb begin
    sync1_d       = raw;
    sync2_d       = sync1_q;
    stable_d      = stable_q;
    stable_dly_d  = stable_q;
    db_cnt_d      = db_cnt_q;
    mode_d        = mode_q;
    selected_d    = selected_q;
    startstop_d   = 1'b0;
    increment_d   = 1'b0;
    decrement_d   = 1'b0;
    rp_d          = rp_q;
    rp_cnt_d      = rp_cnt_q;
    rp_inc_d      = rp_inc_q;
    lock_d        = lock_q;
    bz_d          = bz_q;
    sec_cnt_d     = sec_cnt_q;
    beep_phase_d  = beep_phase_q;
    alarm_prev_d  = alarm_req;
    timer_prev_d  = timer_req;
    ring_src_d    = ring_src_q;
    silence_ack_d = 1'b0;

    for (int unsigned i = 0; i < 5; i++) begin
      if (sync2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          stable_d[i] = ~stable_q[i];
          db_cnt_d[i] = '0;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DW'(1);
        end
      end else begin
        db_cnt_d[i] = '0;
      end
    end

    if (press[B_MODE]) begin
      mode_d     = mode_q + 2'd1;
      selected_d = '0;
    end else if (press[B_SEL]) begin
      selected_d = selected_q + 2'd1;
    end

    if (press[B_STRT] && ring_src_q == 2'd0) startstop_d = 1'b1;

    // lock_q keeps presses ignored after an inc+dec chord until both are up
    if (both_held) lock_d = 1'b1;
    else if (!stable_q[B_INC] && !stable_q[B_DEC]) lock_d = 1'b0;

    if (press[B_MODE] || both_held) begin
      rp_d     = IDLE;
      rp_cnt_d = '0;
    end else begin
      case (rp_q)
        IDLE: begin
          if (!lock_q && press[B_INC]) begin
            increment_d = 1'b1;
            rp_inc_d    = 1'b1;
            rp_d        = HOLD;
            rp_cnt_d    = '0;
          end else if (!lock_q && press[B_DEC]) begin
            decrement_d = 1'b1;
            rp_inc_d    = 1'b0;
            rp_d        = HOLD;
            rp_cnt_d    = '0;
          end
        end
        HOLD, REPEAT: begin
          if (!active_held) begin
            rp_d     = IDLE;
            rp_cnt_d = '0;
          end else if ((rp_q == HOLD   && rp_cnt_q == CW'(HOLD_CYCLES - 1)) ||
                       (rp_q == REPEAT && rp_cnt_q == CW'(REPEAT_CYCLES - 1))) begin
            increment_d = rp_inc_q;
            decrement_d = ~rp_inc_q;
            rp_d        = REPEAT;
            rp_cnt_d    = '0;
          end else begin
            rp_cnt_d = rp_cnt_q + CW'(1);
          end
        end
        default: rp_d = IDLE;
      endcase
    end

    case (bz_q)
      BZ_IDLE: begin
        if (rise_a || rise_t) begin
          bz_d         = BZ_RING;
          ring_src_d   = rise_a ? 2'd1 : 2'd2;
          sec_cnt_d    = '0;
          beep_phase_d = 1'b0;
        end
      end
      BZ_RING: begin
        if (!src_req) begin
          bz_d       = BZ_IDLE;
          ring_src_d = '0;
        end else if (press[B_STRT] ||
                     (tick_1hz && sec_cnt_q == TW'(BUZZ_TIMEOUT_S - 1))) begin
          bz_d          = BZ_MUTED;
          ring_src_d    = '0;
          silence_ack_d = 1'b1;
        end else if (tick_1hz) begin
          beep_phase_d = ~beep_phase_q;
          sec_cnt_d    = sec_cnt_q + TW'(1);
        end
      end
      BZ_MUTED: begin
        if (!alarm_req && !timer_req) bz_d = BZ_IDLE;
      end
      default: bz_d = BZ_IDLE;
    endcase

    buzzer_d = (bz_d == BZ_RING) && !beep_phase_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      stable_q      <= '0;
      stable_dly_q  <= '0;
      db_cnt_q      <= '{default: '0};
      mode_q        <= '0;
      selected_q    <= '0;
      startstop_q   <= 1'b0;
      increment_q   <= 1'b0;
      decrement_q   <= 1'b0;
      rp_q          <= IDLE;
      rp_cnt_q      <= '0;
      rp_inc_q      <= 1'b0;
      lock_q        <= 1'b0;
      bz_q          <= BZ_IDLE;
      sec_cnt_q     <= '0;
      beep_phase_q  <= 1'b0;
      alarm_prev_q  <= 1'b0;
      timer_prev_q  <= 1'b0;
      buzzer_q      <= 1'b0;
      ring_src_q    <= '0;
      silence_ack_q <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      stable_q      <= stable_d;
      stable_dly_q  <= stable_dly_d;
      db_cnt_q      <= db_cnt_d;
      mode_q        <= mode_d;
      selected_q    <= selected_d;
      startstop_q   <= startstop_d;
      increment_q   <= increment_d;
      decrement_q   <= decrement_d;
      rp_q          <= rp_d;
      rp_cnt_q      <= rp_cnt_d;
      rp_inc_q      <= rp_inc_d;
      lock_q        <= lock_d;
      bz_q          <= bz_d;
      sec_cnt_q     <= sec_cnt_d;
      beep_phase_q  <= beep_phase_d;
      alarm_prev_q  <= alarm_prev_d;
      timer_prev_q  <= timer_prev_d;
      buzzer_q      <= buzzer_d;
      ring_src_q    <= ring_src_d;
      silence_ack_q <= silence_ack_d;
    end
  end

  assign mode        = mode_q;
  assign selected    = selected_q;
  assign startstop   = startstop_q;
  assign increment   = increment_q;
  assign decrement   = decrement_q;
  assign buzzer      = buzzer_q;
  assign ring_src    = ring_src_q;
  assign silence_ack = silence_ack_q;

endmodule

// File: doc/clock_ui_controller.md
Name: clock_ui_controller

Overview:
Front-end controller for the ps1_clock design. It debounces the five user buttons and sequences the mode and field selection. It generates single-cycle startstop/increment/decrement strobes (with auto-repeat on hold) for the clock, alarm, timer and stopwatch datapaths, and arbitrates the alarm and timer buzzer requests onto one beeping buzzer with silence and timeout handling.

Parameters:
DEBOUNCE_CYCLES, 50000, consecutive cycles a synchronized raw button must differ from its stable value before the stable value flips
HOLD_CYCLES, 50000000, cycles inc/dec must stay held after the first strobe before auto-repeat starts
REPEAT_CYCLES, 10000000, cycles between auto-repeat strobes
BUZZ_TIMEOUT_S, 60, tick_1hz pulses after which a ringing buzzer is auto-silenced

Ports:
clk  input  1  system clock
reset  input  1  reset, asynchronous, active-high
tick_1hz  input  1  one-cycle pulse once per second, synchronous to clk
btn_mode  input  1  raw mode button, asynchronous
btn_select  input  1  raw field-select button, asynchronous
btn_start  input  1  raw start/stop button, asynchronous
btn_inc  input  1  raw increment button, asynchronous
btn_dec  input  1  raw decrement button, asynchronous
alarm_req  input  1  level buzzer request from the alarm block
timer_req  input  1  level buzzer request from the timer block
mode  output  2  0 CLOCK, 1 ALARM, 2 TIMER, 3 STOPWATCH
selected  output  2  field under edit: 0 sec, 1 min, 2 hour, 3 day
startstop  output  1  one-cycle strobe
increment  output  1  one-cycle strobe
decrement  output  1  one-cycle strobe
buzzer  output  1  buzzer drive
ring_src  output  2  0 none, 1 alarm, 2 timer
silence_ack  output  1  one-cycle pulse when a ringing buzzer is silenced

Behaviour:
- Reset (async): all outputs 0, synchronizers 0, debounced states 0, counters 0, all FSMs idle. Reset mid-hold or mid-ring aborts immediately, with no strobe afterwards.
- Input path: each button passes through a 2-FF synchronizer, then a debouncer. The debounce counter increments while the synced value differs from the stable value and clears when they agree. The stable value flips when the count reaches DEBOUNCE_CYCLES-1. A press event is a rising edge of the stable value, so one press produces one event. Total latency is 2 sync cycles plus DEBOUNCE_CYCLES plus 1.
- Mode: a btn_mode press sets mode to (mode+1) mod 4 and clears selected to 0 in the same cycle. It also cancels any auto-repeat (repeat FSM to IDLE).
- Select: a btn_select press sets selected to (selected+1) mod 4, wrapping 3 to 0.
- startstop: a btn_start press emits one startstop strobe the following cycle, except when ring_src != 0. In that case the press is consumed as silence: no strobe, silence_ack pulses.
- Repeat FSM, states IDLE, HOLD, REPEAT:
  - IDLE: an inc or dec press emits the matching strobe next cycle and moves to HOLD with the counter cleared.
  - HOLD: when the counter reaches HOLD_CYCLES-1, emit a strobe and move to REPEAT with the counter cleared.
  - REPEAT: emit a strobe every REPEAT_CYCLES.
  - Release of the active button returns to IDLE with no strobe.
  - If both inc and dec are stably high at once, go to IDLE and emit no strobes until both are released.
  - increment and decrement are never high in the same cycle.
- Buzzer FSM, states BZ_IDLE, BZ_RING, BZ_MUTED:
  - BZ_IDLE: a rising edge of a request moves to BZ_RING with ring_src set to that source. Alarm wins if both rise in the same cycle. A request already high at reset exit counts as a rising edge.
  - In BZ_RING, a rising edge of the other request is ignored.
  - BZ_RING: beep_phase clears on entry and toggles on each tick_1hz. buzzer = ~beep_phase, i.e. beeps at 0.5 Hz starting high on entry.
  - BZ_RING: a second counter counts tick_1hz. Reaching BUZZ_TIMEOUT_S, or a btn_start press, moves to BZ_MUTED and pulses silence_ack.
  - BZ_RING: if the ringing source's request drops, move to BZ_IDLE with no ack.
  - BZ_MUTED: buzzer 0, ring_src 0. Return to BZ_IDLE only when both requests are low, so a latched alarm level cannot re-trigger.
- Strobes are registered outputs; at most one strobe per button event per cycle.

Test Plan:
- Bouncy btn_mode (5 glitches shorter than DEBOUNCE_CYCLES, then stable high) with DEBOUNCE_CYCLES=4 -> exactly one mode increment; four presses -> mode sequence 1,2,3,0; selected cleared each time.
- selected=2 via two select presses, then mode press -> mode increments, selected=0; four select presses -> selected wraps back to 0.
- btn_inc held for 100 cycles with HOLD_CYCLES=20, REPEAT_CYCLES=10 -> strobes at first press, +20, then every 10 cycles (≈9 total); release -> no further strobes; inc+dec together -> zero strobes.
- alarm_req and timer_req rise in the same cycle -> ring_src=1, buzzer toggles on ticks; BUZZ_TIMEOUT_S=3 -> after 3 ticks silence_ack pulse, buzzer 0; alarm_req held high -> stays MUTED; drop both, raise timer_req -> ring_src=2.
- Ringing plus btn_start press -> silence_ack, no startstop strobe; next btn_start press -> startstop strobe.
- Reset asserted mid-REPEAT and mid-RING -> all outputs 0 asynchronously; after release, no strobe until a fresh press.
